pfc_cmd_arbiter: RTL and testbench
==================================

PFC_CMD_ARBITER -- requirements
Module: pfc_cmd_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, range 1-15: cycles the command is held on pfc_cmd per access.
REQ-002 SHALL have port csi_clk, input, 1: the single clock; all logic is posedge-driven.
REQ-003 SHALL have port rsi_reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports reqN_valid, input, 1, N=0,1: requester N has an access pending.
REQ-005 SHALL have ports reqN_write, input, 1: 1 = write, 0 = read.
REQ-006 SHALL have ports reqN_bank, input, 2: target PFC bank, 0-3.
REQ-007 SHALL have ports reqN_addr, input, 2: register address within the bank.
REQ-008 SHALL have ports reqN_wdata, input, 32: write data.
REQ-009 SHALL have ports reqN_ready, output, 1: the request is accepted this cycle.
REQ-010 SHALL have ports reqN_rvalid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have ports reqN_rdata, output, 32: read result.
REQ-012 SHALL have port pfc_cmd, output, 37, laid out as {write[36], bank[35:34], addr[33:32], wdata[31:0]}.
REQ-013 SHALL have port pfc_resp, input, 32: readdata from the selected bank.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement a state machine with states IDLE, ACCESS and DONE.
REQ-016 Transfer rule: a request transfers on reqN_valid && reqN_ready.
- reqN_ready is combinational.
- reqN_ready is high only in IDLE, for the granted requester only.
REQ-017 Grant in IDLE:
- Only one requester valid: that requester is granted.
- Both valid: the requester not granted most recently wins (round-robin).
- The last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-018 On transfer, the block SHALL register write, bank, addr, wdata and the grant index, then enter ACCESS.
REQ-019 In ACCESS:
- pfc_cmd[35:0] is driven from the registered fields for exactly ACCESS_CYCLES cycles, counted by a 4-bit counter.
- pfc_cmd[36] is high only in the first ACCESS cycle, and only for a write, giving a single write strobe.
REQ-020 On the last ACCESS cycle, for a read, the block SHALL capture pfc_resp into the granted requester's reqN_rdata register.
REQ-021 DONE SHALL last one cycle:
- reqN_rvalid is high for the granted requester, for both reads and writes.
- The next state is IDLE.
REQ-022 On a write, reqN_rdata SHALL hold its previous value.
REQ-023 The non-granted requester's rdata SHALL never change.
REQ-024 Outside ACCESS, pfc_cmd[36] SHALL be 0 and pfc_cmd[35:0] SHALL hold the last driven value, so bank select stays stable.
REQ-025 Throughput SHALL be one access per ACCESS_CYCLES+2 cycles, counting the IDLE accept cycle.
- Back-to-back requests from the same requester are accepted in the IDLE that follows DONE.
REQ-026 Request changes while busy SHALL be ignored.
- reqN_valid deasserting before acceptance SHALL drop the request with no side effects.
REQ-027 When both requesters are continuously valid, grants SHALL strictly alternate 0,1,0,1,...

Reset
REQ-028 While rsi_reset_n is low, the block SHALL hold these values:
- state = IDLE, pfc_cmd = 37'h0.
- reqN_ready = 0 and reqN_rvalid = 0.
- reqN_rdata = 32'h0.
- busy = 0, counter = 0, last-grant = 1.
REQ-029 Reset asserted mid-access SHALL abort the access.
- No rvalid is issued, and any write strobe ends immediately.
- After release, the first cycle is IDLE.
REQ-030 Outputs SHALL take their reset values asynchronously on the falling edge of rsi_reset_n.

Verification
REQ-031 Single write, ACCESS_CYCLES=2:
- Stimulus: req0 write, bank 2, addr 1, wdata 32'hA5A5_0F0F.
- Response: pfc_cmd = 37'h1_A5A5_0F0F | (2<<34) | (1<<32) with bit36=1 for 1 cycle, held 2 cycles, req0_rvalid 3 cycles after accept.
REQ-032 Single read:
- Stimulus: req1 read, bank 3, addr 0; pfc_resp = 32'h1234_5678 in the last ACCESS cycle.
- Response: req1_rdata = 32'h1234_5678 at req1_rvalid; req0_rdata unchanged.
REQ-033 Contention:
- Stimulus: both requesters valid from reset release, 4 accesses each.
- Response: grant order 0,1,0,1,..., each rvalid on the matching port only, pfc_cmd[36] never high for reads.
REQ-034 Reset mid-access:
- Stimulus: rsi_reset_n low during the second ACCESS cycle of a write.
- Response: no rvalid; pfc_cmd = 0; busy = 0; the next request is accepted normally after release.
REQ-035 Withdrawn request and parameter sweep:
- Stimulus: req0_valid pulsed low before ready while busy; then ACCESS_CYCLES = 1 and 15.
- Response: no access issued for the withdrawn request; access spacing of 3 and 17 cycles respectively.

Source files
------------

// File: rtl/pfc_cmd_arbiter.sv
// Two-requester round-robin arbiter in front of a PFC register port.
// Each accepted request owns pfc_cmd for ACCESS_CYCLES cycles, then pulses rvalid.
module pfc_cmd_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,

  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [1:0]  req0_bank,
  input  logic [1:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_rvalid,
  output logic [31:0] req0_rdata,

  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [1:0]  req1_bank,
  input  logic [1:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_rvalid,
  output logic [31:0] req1_rdata,

  output logic [36:0] pfc_cmd,
  input  logic [31:0] pfc_resp,
  output logic        busy
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        write_q, write_d;
  logic [35:0] fields_q, fields_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic grant;
  logic idle;
  logic accept;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = ~req0_valid;
    end
  end

  // Ready is gated by reset so it drops the instant reset asserts.
  assign idle       = rsi_reset_n && (state_q == StIdle);
  assign req0_ready = idle && req0_valid && !grant;
  assign req1_ready = idle && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    write_d      = write_q;
    fields_d     = fields_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StAccess;
          cnt_d        = 4'd0;
          grant_d      = grant;
          last_grant_d = grant;
          if (grant) begin
            write_d  = req1_write;
            fields_d = {req1_bank, req1_addr, req1_wdata};
          end else begin
            write_d  = req0_write;
            fields_d = {req0_bank, req0_addr, req0_wdata};
          end
        end
      end
      StAccess: begin
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cnt_d   = 4'd0;
          if (!write_q) begin
            if (grant_q) begin
              rdata1_d = pfc_resp;
            end else begin
              rdata0_d = pfc_resp;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      write_q      <= 1'b0;
      fields_q     <= 36'h0;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      write_q      <= write_d;
      fields_q     <= fields_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Fields stay on the bus after the access so the bank select does not glitch.
  assign pfc_cmd     = {(state_q == StAccess) && (cnt_q == 4'd0) && write_q, fields_q};
  assign busy        = (state_q != StIdle);
  assign req0_rvalid = (state_q == StDone) && !grant_q;
  assign req1_rvalid = (state_q == StDone) && grant_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;

endmodule

// File: tb/tb_pfc_cmd_arbiter.sv
// Scoreboard bench for pfc_cmd_arbiter: a cycle-count reference model predicts
// grants and completions; a monitor pops and checks completions independently.
module tb_pfc_cmd_arbiter;

  localparam int MainAc = 2;

  typedef struct {
    logic        valid;
    logic        write;
    logic [1:0]  bank;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          done;
    logic        port;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [1:0]  req0_bank, req0_addr, req1_bank, req1_addr;
  logic [31:0] req0_wdata, req1_wdata, pfc_resp;
  logic        req0_ready, req0_rvalid, req1_ready, req1_rvalid, busy;
  logic [31:0] req0_rdata, req1_rdata;
  logic [36:0] pfc_cmd;

  logic        a1_r0, a1_r1, a1_rv0, a1_rv1, a1_busy;
  logic [31:0] a1_rd0, a1_rd1;
  logic [36:0] a1_cmd;
  logic        a15_r0, a15_r1, a15_rv0, a15_rv1, a15_busy;
  logic [31:0] a15_rd0, a15_rd1;
  logic [36:0] a15_cmd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state: cycle numbers rather than FSM states.
  int          m_free;
  int          m_start;
  logic        m_wr;
  logic        m_last;
  logic [35:0] m_cmd_lo;
  logic [31:0] m_rdata [2];
  exp_t        expq [$];

  int last1, last15, tick;

  always #5 clk = ~clk;

  pfc_cmd_arbiter #(.ACCESS_CYCLES(MainAc)) u_dut (
    .csi_clk(clk), .rsi_reset_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_bank(req0_bank),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_bank(req1_bank),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .pfc_cmd(pfc_cmd), .pfc_resp(pfc_resp), .busy(busy)
  );

  pfc_cmd_arbiter #(.ACCESS_CYCLES(1)) u_ac1 (
    .csi_clk(clk), .rsi_reset_n(rst_n),
    .req0_valid(1'b1), .req0_write(1'b1), .req0_bank(2'd1), .req0_addr(2'd2),
    .req0_wdata(32'h0), .req0_ready(a1_r0), .req0_rvalid(a1_rv0), .req0_rdata(a1_rd0),
    .req1_valid(1'b0), .req1_write(1'b0), .req1_bank(2'd0), .req1_addr(2'd0),
    .req1_wdata(32'h0), .req1_ready(a1_r1), .req1_rvalid(a1_rv1), .req1_rdata(a1_rd1),
    .pfc_cmd(a1_cmd), .pfc_resp(32'h0), .busy(a1_busy)
  );

  pfc_cmd_arbiter #(.ACCESS_CYCLES(15)) u_ac15 (
    .csi_clk(clk), .rsi_reset_n(rst_n),
    .req0_valid(1'b1), .req0_write(1'b1), .req0_bank(2'd1), .req0_addr(2'd2),
    .req0_wdata(32'h0), .req0_ready(a15_r0), .req0_rvalid(a15_rv0), .req0_rdata(a15_rd0),
    .req1_valid(1'b0), .req1_write(1'b0), .req1_bank(2'd0), .req1_addr(2'd0),
    .req1_wdata(32'h0), .req1_ready(a15_r1), .req1_rvalid(a15_rv1), .req1_rdata(a15_rd1),
    .pfc_cmd(a15_cmd), .pfc_resp(32'h0), .busy(a15_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] resp_of(input int c);
    return 32'h1234_5678 ^ (32'(c) * 32'h9E37_79B9);
  endfunction

  function automatic req_t mk(input logic v, input logic w, input logic [1:0] b,
                              input logic [1:0] a, input logic [31:0] d);
    req_t r;
    r.valid = v; r.write = w; r.bank = b; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rnd(input int unsigned pct);
    req_t r;
    r.valid = ($urandom_range(99) < pct);
    r.write = 1'($urandom_range(1));
    r.bank  = 2'($urandom_range(3));
    r.addr  = 2'($urandom_range(3));
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_free = 0; m_start = -100; m_wr = 1'b0; m_last = 1'b1; m_cmd_lo = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    expq.delete();
  endtask

  // Predicts this cycle's outputs, then records any acceptance.
  task automatic model_cycle(input req_t r0, input req_t r1);
    logic ebusy, estrobe, er0, er1, g;
    req_t r;
    exp_t it;
    ebusy   = (cyc < m_free);
    estrobe = m_wr && (cyc == m_start + 1);
    er0 = 1'b0; er1 = 1'b0; g = 1'b0;
    if (!ebusy && (r0.valid || r1.valid)) begin
      g = (r0.valid && r1.valid) ? !m_last : r1.valid;
      if (g) er1 = 1'b1; else er0 = 1'b1;
    end
    chk("busy", 64'(busy), 64'(ebusy));
    chk("ready0", 64'(req0_ready), 64'(er0));
    chk("ready1", 64'(req1_ready), 64'(er1));
    chk("pfc_cmd", 64'(pfc_cmd), 64'({estrobe, m_cmd_lo}));
    if (er0 || er1) begin
      r        = g ? r1 : r0;
      m_start  = cyc;
      m_wr     = r.write;
      m_free   = cyc + MainAc + 2;
      m_last   = g;
      m_cmd_lo = {r.bank, r.addr, r.wdata};
      if (!r.write) m_rdata[g] = resp_of(cyc + MainAc);
      it.done = cyc + MainAc + 1;
      it.port = g;
      it.rd0  = m_rdata[0];
      it.rd1  = m_rdata[1];
      expq.push_back(it);
    end
  endtask

  task automatic step(input req_t r0, input req_t r1);
    @(negedge clk);
    cyc++;
    req0_valid = r0.valid; req0_write = r0.write; req0_bank = r0.bank;
    req0_addr  = r0.addr;  req0_wdata = r0.wdata;
    req1_valid = r1.valid; req1_write = r1.write; req1_bank = r1.bank;
    req1_addr  = r1.addr;  req1_wdata = r1.wdata;
    pfc_resp   = resp_of(cyc);
    #1;
    model_cycle(r0, r1);
  endtask

  task automatic reset_checks();
    chk("rst_pfc_cmd", 64'(pfc_cmd), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'({req1_ready, req0_ready}), 64'(0));
    chk("rst_rvalid", 64'({req1_rvalid, req0_rvalid}), 64'(0));
    chk("rst_rdata0", 64'(req0_rdata), 64'(0));
    chk("rst_rdata1", 64'(req1_rdata), 64'(0));
  endtask

  // Called just after step() returns; asserts reset between clock edges.
  task automatic mid_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 reset_checks();
    model_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Completion monitor.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0 && expq[0].done == cyc) begin
        it = expq.pop_front();
        chk("rvalid", 64'({req1_rvalid, req0_rvalid}), it.port ? 64'(2) : 64'(1));
        chk("rdata0", 64'(req0_rdata), 64'(it.rd0));
        chk("rdata1", 64'(req1_rdata), 64'(it.rd1));
      end else begin
        chk("rvalid_quiet", 64'({req1_rvalid, req0_rvalid}), 64'(0));
      end
    end
  end

  always @(negedge rst_n) begin
    last1  = -1;
    last15 = -1;
  end

  // Back-to-back spacing for the ACCESS_CYCLES=1 and =15 instances.
  initial begin
    tick = 0;
    forever begin
      @(negedge clk);
      #2;
      tick++;
      if (rst_n) begin
        chk("aux_rv1", 64'({a1_rv1, a15_rv1, a1_r1, a15_r1}), 64'(0));
        if (a1_rv0) begin
          if (last1 >= 0) chk("spacing_ac1", 64'(tick - last1), 64'(3));
          chk("aux1_done", 64'({a1_busy, a1_r0, a1_cmd}), 64'({2'b10, 1'b0, 36'h6_0000_0000}));
          chk("aux1_rdata", 64'({a1_rd0, a1_rd1}), 64'(0));
          last1 = tick;
        end
        if (a15_rv0) begin
          if (last15 >= 0) chk("spacing_ac15", 64'(tick - last15), 64'(17));
          chk("aux15_done", 64'({a15_busy, a15_r0, a15_cmd}), 64'({2'b10, 1'b0, 36'h6_0000_0000}));
          chk("aux15_rdata", 64'({a15_rd0, a15_rd1}), 64'(0));
          last15 = tick;
        end
      end
    end
  end

  initial begin
    req_t idle;
    idle = mk(1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
    rst_n = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_bank = '0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_bank = '0; req1_addr = '0; req1_wdata = '0;
    pfc_resp = '0;
    model_reset();

    #2 rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 reset_checks();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset release: reads only, so no strobe may appear.
    for (int i = 0; i < 8 * (MainAc + 2); i++) begin
      req_t a, b;
      a = rnd(100); b = rnd(100);
      a.write = 1'b0; b.write = 1'b0;
      step(a, b);
    end

    // Single write, then single read.
    step(mk(1'b1, 1'b1, 2'd2, 2'd1, 32'hA5A5_0F0F), idle);
    step(idle, idle);
    chk("write_cmd_literal", 64'(pfc_cmd), 64'(37'h19_A5A5_0F0F));
    repeat (3) step(idle, idle);
    step(idle, mk(1'b1, 1'b0, 2'd3, 2'd0, 32'h0));
    repeat (4) step(idle, idle);

    // Reset during the second access cycle of a write, then a normal access.
    step(mk(1'b1, 1'b1, 2'd1, 2'd2, 32'hDEAD_BEEF), idle);
    step(idle, idle);
    step(idle, idle);
    mid_reset();
    step(mk(1'b1, 1'b0, 2'd0, 2'd3, 32'h0), idle);
    repeat (4) step(idle, idle);

    // req0 pulses while busy and withdraws before the idle cycle.
    step(idle, mk(1'b1, 1'b0, 2'd2, 2'd2, 32'h0));
    step(mk(1'b1, 1'b1, 2'd1, 2'd1, 32'h1111_2222), idle);
    step(idle, idle);
    step(mk(1'b1, 1'b1, 2'd1, 2'd1, 32'h3333_4444), idle);
    repeat (4) step(idle, idle);

    // Random traffic with varying request density.
    for (int i = 0; i < 500; i++) begin
      int unsigned pct;
      pct = (i < 200) ? 30 : ((i < 350) ? 90 : 60);
      step(rnd(pct), rnd(pct));
    end
    repeat (2 * (MainAc + 2)) step(idle, idle);

    chk("queue_drained", 64'(expq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
